mult_div_seq: RTL and testbench

Iterative signed multiply/divide sequencer that owns the HI and LO registers of the multicycle CPU. The main control unit issues a one-cycle start for MULT or DIV with the operands from A and B. The block sequences a shared 32-step shift/add-subtract datapath, holds `busy` so the control FSM can stall, and presents results on `hi`/`lo`, which feed the MemtoReg mux for MFHI/MFLO.

---
 rtl/mult_div_seq_if.sv | 29 ++
 rtl/mult_div_seq.sv | 204 ++++++++++++++++++++
 tb/tb_mult_div_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_seq_if.sv
// Handshake and data bundle between the main control unit and the
// HI/LO multiply/divide sequencer.
//   start_mult, start_div : one-cycle operation requests (master -> slave)
//   a, b                  : operands, sampled on the accepting edge
//   busy                  : operation in progress, control FSM stalls on it
//   done                  : one-cycle pulse, hi/lo valid in the same cycle
//   div_zero              : one-cycle pulse with done when the divisor was 0
//   hi, lo                : result registers read by MFHI/MFLO
interface mult_div_seq_if;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start_mult, start_div, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_seq.sv
// Iterative signed 32-bit multiply/divide sequencer owning HI and LO.
// Multiply: radix-2 Booth, 64-bit product into {hi,lo}.
// Divide: restoring division on magnitudes, then sign fix-up;
//         lo = quotient (truncated toward zero), hi = remainder (sign of dividend).
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high, clears all state
//   bus   : mult_div_seq_if.slave (starts, operands, busy/done/div_zero, hi/lo)
//
// state | meaning
// IDLE  | waiting for start_mult / start_div
// MULT  | 32 Booth iterations, then one edge to load {hi,lo}
// DIV   | 32 restoring-division iterations
// FIX   | sign correction of quotient/remainder, load {hi,lo}
// DONE  | one-cycle done pulse, then back to IDLE
module mult_div_seq (
    input  logic          clk,
    input  logic          reset,
    mult_div_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [4:0]  cnt;
    logic        iter_last;     // all 32 iterations done; next edge leaves MULT/DIV
    logic [32:0] acc;           // Booth upper partial product / division remainder
    logic [31:0] lsr;           // multiplier bits / dividend shifting out, quotient in
    logic        booth_q;       // Booth q(-1) bit
    logic [31:0] opnd;          // multiplicand / divisor magnitude
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        accept_mult;
    logic        accept_div;
    logic        div_by_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // Multiply wins when both starts arrive together.
    assign accept_mult = (state == S_IDLE) && bus.start_mult;
    assign accept_div  = (state == S_IDLE) && bus.start_div && !bus.start_mult;
    assign div_by_zero = accept_div && (bus.b == 32'd0);

    assign a_mag = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    assign b_mag = bus.b[31] ? (~bus.b + 32'd1) : bus.b;

    // Shared 33-bit add/subtract. Bit 33 of the result is the carry out,
    // which for the unsigned division subtract means "no borrow".
    logic [1:0]  booth_pair;
    logic        add_sub;
    logic [32:0] add_a;
    logic [32:0] add_b;
    logic [32:0] add_b_x;
    logic [33:0] add_res;
    logic        div_ge;
    logic        booth_op;
    logic [32:0] acc_upd;

    always_comb begin
        booth_pair = {lsr[0], booth_q};
        if (state == S_DIV) begin
            add_a   = {acc[31:0], lsr[31]};
            add_b   = {1'b0, opnd};
            add_sub = 1'b1;
        end else begin
            add_a   = acc;
            add_b   = {opnd[31], opnd};
            add_sub = (booth_pair == 2'b10);
        end
        add_b_x  = add_sub ? ~add_b : add_b;
        add_res  = {1'b0, add_a} + {1'b0, add_b_x} + {33'd0, add_sub};
        div_ge   = add_res[33];
        booth_op = (booth_pair == 2'b01) || (booth_pair == 2'b10);
        acc_upd  = booth_op ? add_res[32:0] : acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept_mult) begin
                    state_nxt = S_MULT;
                end else if (div_by_zero) begin
                    state_nxt = S_DONE;
                end else if (accept_div) begin
                    state_nxt = S_DIV;
                end
            end
            S_MULT: begin
                if (iter_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DIV: begin
                if (iter_last) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 5'd0;
            iter_last <= 1'b0;
            acc       <= 33'd0;
            lsr       <= 32'd0;
            booth_q   <= 1'b0;
            opnd      <= 32'd0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else begin
            dz <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_mult) begin
                        acc       <= 33'd0;
                        lsr       <= bus.b;
                        booth_q   <= 1'b0;
                        opnd      <= bus.a;
                        cnt       <= 5'd0;
                        iter_last <= 1'b0;
                    end else if (div_by_zero) begin
                        dz <= 1'b1;
                    end else if (accept_div) begin
                        acc       <= 33'd0;
                        lsr       <= a_mag;
                        opnd      <= b_mag;
                        neg_q     <= bus.a[31] ^ bus.b[31];
                        neg_r     <= bus.a[31];
                        cnt       <= 5'd0;
                        iter_last <= 1'b0;
                    end
                end
                S_MULT: begin
                    if (iter_last) begin
                        hi_r      <= acc[31:0];
                        lo_r      <= lsr;
                        iter_last <= 1'b0;
                    end else begin
                        // arithmetic shift right of {acc, lsr, booth_q}
                        acc     <= {acc_upd[32], acc_upd[32:1]};
                        lsr     <= {acc_upd[0], lsr[31:1]};
                        booth_q <= lsr[0];
                        cnt     <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            iter_last <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    if (iter_last) begin
                        iter_last <= 1'b0;
                    end else begin
                        acc <= div_ge ? add_res[32:0] : add_a;
                        lsr <= {lsr[30:0], div_ge};
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            iter_last <= 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    // -2^31 / -1 yields magnitude 2^31 with neg_q=0, i.e. 0x80000000
                    lo_r <= neg_q ? (~lsr + 32'd1) : lsr;
                    hi_r <= neg_r ? (~acc[31:0] + 32'd1) : acc[31:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == S_MULT) || (state == S_DIV) || (state == S_FIX);
    assign bus.done     = (state == S_DONE);
    assign bus.div_zero = dz;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: the driver pushes expected results
// (hi, lo, div_zero, done cycle) when it issues a start; a negedge monitor
// pops and compares whenever done is presented.
`timescale 1ns/1ps
module tb_mult_div_seq;

    logic clk = 1'b0;
    logic reset;

    mult_div_seq_if bus();

    mult_div_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // cyc = index of the most recent rising edge; cycle k is observed at the
    // falling edge while cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural reference: plain 64-bit signed arithmetic. SV division
    // truncates toward zero and % takes the dividend's sign.
    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (!is_div) begin
            p  = sa * sbv;
            hi = p[63:32];
            lo = p[31:0];
        end else begin
            p  = sa / sbv;
            lo = p[31:0];
            p  = sa % sbv;
            hi = p[31:0];
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e = sb.pop_front();
                check("hi", 64'(bus.hi), 64'(e.hi));
                check("lo", 64'(bus.lo), 64'(e.lo));
                check("div_zero", 64'(bus.div_zero), 64'(e.dz));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (bus.div_zero) begin
            tests++;
            fails++;
            $display("FAIL div_zero_without_done: div_zero=1 done=0 at cycle %0d, expected 0", cyc);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy=%0b done=%0b after %0d cycles, expected idle", bus.busy, bus.done, n);
        end
    endtask

    // Called at a falling edge; the start is accepted on the next rising edge.
    // Returns at the falling edge of cycle 0 with the starts removed.
    task automatic drive(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input bit edz, input int lat);
        exp_t e;
        bus.start_mult = m;
        bus.start_div  = d;
        bus.a          = a;
        bus.b          = b;
        e.hi  = ehi;
        e.lo  = elo;
        e.dz  = edz;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = $urandom;
        bus.b          = $urandom;
    endtask

    task automatic wait_done(input int exp_busy, input string name);
        int n;
        int nb;
        n  = 0;
        nb = 0;
        while (!bus.done && n < 80) begin
            if (bus.busy) nb++;
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, expected a done pulse", name, n);
        end
        check({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
        check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input bit edz,
                          input int lat, input string name);
        wait_idle();
        drive(m, d, a, b, ehi, elo, edz, lat);
        wait_done(lat, name);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit          is_div;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] ehi;
        logic [31:0] elo;

        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_div_zero", 64'(bus.div_zero), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(1, 0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33, "mul_m3x7");
        run_op(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0, 33, "mul_maxpos");
        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 33, "mul_minneg");
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34, "div_m7by2");
        run_op(0, 1, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 34, "div_7bym2");
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 34, "div_ovf");

        // divide by zero leaves the 5*6 result in place
        run_op(1, 0, 32'd5, 32'd6, 32'd0, 32'd30, 0, 33, "mul_5x6");
        run_op(0, 1, 32'd9, 32'd0, 32'd0, 32'd30, 1, 0, "div_by_zero");
        @(negedge clk);
        check("dz_busy_after", 64'(bus.busy), 64'd0);
        check("dz_hi_hold", 64'(bus.hi), 64'd0);
        check("dz_lo_hold", 64'(bus.lo), 64'd30);

        // reset in the middle of a multiply
        wait_idle();
        drive(1, 0, 32'd3, 32'd5, 32'd0, 32'd15, 0, 33);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_hi", 64'(bus.hi), 64'd0);
        check("midrst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;
        drive(1, 0, 32'd2, 32'd3, 32'd0, 32'd6, 0, 33);
        check("start_after_reset_busy", 64'(bus.busy), 64'd1);
        wait_done(33, "after_rst");

        // both starts: multiply wins; later div starts are ignored
        wait_idle();
        drive(1, 1, 32'd4, 32'd2, 32'd0, 32'd8, 0, 33);
        repeat (5) @(negedge clk);
        bus.start_div = 1'b1;
        bus.a         = 32'd100;
        bus.b         = 32'd3;
        @(negedge clk);
        bus.start_div = 1'b0;
        wait_done(27, "arb");
        bus.start_div = 1'b1;
        bus.a         = 32'd12;
        bus.b         = 32'd4;
        @(negedge clk);
        bus.start_div = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("arb_idle_busy", 64'(bus.busy), 64'd0);
            @(negedge clk);
        end

        // randomized, back-to-back where possible
        for (int i = 0; i < 1000; i++) begin
            is_div = 1'($urandom_range(0, 1));
            ra     = $urandom;
            rb     = $urandom;
            case ($urandom_range(0, 9))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'd1;
                3: ra = 32'd0;
                4: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if (is_div && rb == 32'd0) rb = 32'd1;
            model(is_div, ra, rb, ehi, elo);
            run_op(!is_div, is_div, ra, rb, ehi, elo, 0, is_div ? 34 : 33, is_div ? "rand_div" : "rand_mul");
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
